uart_rx: RTL and testbench

Serial-to-parallel UART receiver. It is the receive-side counterpart of the tuner's UART transmitter and uses the same 8N1 framing and the same `cc_per_bit` bit period. It synchronizes the `rx_i` line, detects and qualifies start bits, and samples each bit at mid-period. Each received byte is presented on a one-entry valid/ready output register feeding the tuner's command/control logic.

---
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, 8N1 (8E1 with UART_RX_PARITY_EN).
// Received bytes are held in a one-entry valid/ready output register.
module uart_rx #(
  parameter logic [11:0] cc_per_bit = 12'd1250
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [11:0] HALF_M1 = cc_per_bit / 12'd2 - 12'd1;
  localparam logic [11:0] FULL_M1 = cc_per_bit - 12'd1;

  logic [1:0]  r_sync;
  logic [2:0]  r_state;
  logic [11:0] r_cc;
  logic [3:0]  r_bit;
  logic [7:0]  r_shift;
  logic        w_rx_s;
  logic        w_half;
  logic        w_full;
  logic        w_bad_par;

  assign w_rx_s = r_sync[1];
  assign w_half = (r_cc == HALF_M1);
  assign w_full = (r_cc == FULL_M1);

`ifdef UART_RX_PARITY_EN
  logic r_perr;
  assign w_bad_par = r_perr;
`else
  assign w_bad_par    = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync      <= 2'b11;
      r_state     <= S_IDLE;
      r_cc        <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr       <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      r_sync      <= {r_sync[0], rx_i};
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      if (valid_o && ready_i)
        valid_o <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cc  <= '0;
          r_bit <= '0;
          if (!w_rx_s)
            r_state <= S_START;
        end
        S_START: begin
          if (w_half) begin
            r_cc    <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cc <= r_cc + 12'd1;
          end
        end
        S_DATA: begin
          if (w_full) begin
            r_cc                <= '0;
            r_shift[r_bit[2:0]] <= w_rx_s;
            r_bit               <= r_bit + 4'd1;
            if (r_bit == 4'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cc <= r_cc + 12'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_full) begin
            r_cc    <= '0;
            r_perr  <= ^{r_shift, w_rx_s};
            r_state <= S_STOP;
          end else begin
            r_cc <= r_cc + 12'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_full) begin
            r_cc    <= '0;
            r_state <= S_IDLE;
            // One error per frame: parity beats framing beats overrun
            if (w_bad_par) begin
`ifdef UART_RX_PARITY_EN
              parity_err_o <= 1'b1;
`endif
            end else if (!w_rx_s) begin
              frame_err_o <= 1'b1;
            end else if (!valid_o || ready_i) begin
              data_o  <= r_shift;
              valid_o <= 1'b1;
            end else begin
              overrun_o <= 1'b1;
            end
          end else begin
            r_cc <= r_cc + 12'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cc    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rxq[$];
  int vcyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;

  uart_rx #(.cc_per_bit(12'(CPB))) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .rx_i(rx_i),
    .ready_i(ready_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (valid_o) vcyc++;
    if (valid_o && ready_i) rxq.push_back(data_o);
    if (frame_err_o) fe_cnt++;
    if (overrun_o) ov_cnt++;
    if (parity_err_o) pe_cnt++;
  end

  task automatic clear_mon();
    rxq.delete();
    vcyc = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    pe_cnt = 0;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_i = b;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ ~par_ok, CPB);
`else
    if (!par_ok) rx_i = 1'b1;
`endif
    drive_bit(stop_b, CPB);
    rx_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_tests++;
    if (data_o !== 8'h00) begin
      n_fail++; $display("FAIL reset_data got %h want 00", data_o);
    end
    n_tests++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", valid_o);
    end
    n_tests++;
    if ({frame_err_o, overrun_o, parity_err_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_errs got %b want 000", {frame_err_o, overrun_o, parity_err_o});
    end
    reset_i = 1'b0;
    repeat (5) @(negedge clk_i);
  endtask

  task automatic test_single();
    clear_mon();
    ready_i = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (20) @(negedge clk_i);
    n_tests++;
    if (rxq.size() !== 1) begin
      n_fail++; $display("FAIL single_count got %0d want 1", rxq.size());
    end else begin
      n_tests++;
      if (rxq[0] !== 8'hA5) begin
        n_fail++; $display("FAIL single_data got %h want a5", rxq[0]);
      end
    end
    n_tests++;
    if (vcyc !== 1) begin
      n_fail++; $display("FAIL single_valid_width got %0d want 1", vcyc);
    end
    n_tests++;
    if (fe_cnt + ov_cnt + pe_cnt !== 0) begin
      n_fail++;
      $display("FAIL single_errs got fe=%0d ov=%0d pe=%0d want 0", fe_cnt, ov_cnt, pe_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
    clear_mon();
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, 1'b1);
    repeat (20) @(negedge clk_i);
    n_tests++;
    if (rxq.size() !== 3) begin
      n_fail++; $display("FAIL b2b_count got %0d want 3", rxq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (rxq[i] !== exp[i]) begin
          n_fail++; $display("FAIL b2b_data%0d got %h want %h", i, rxq[i], exp[i]);
        end
      end
    end
    n_tests++;
    if (fe_cnt !== 0) begin
      n_fail++; $display("FAIL b2b_frame_err got %0d want 0", fe_cnt);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    ready_i = 1'b1;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    n_tests++;
    if (vcyc + fe_cnt + ov_cnt + pe_cnt !== 0) begin
      n_fail++;
      $display("FAIL glitch_quiet got v=%0d fe=%0d ov=%0d pe=%0d want 0", vcyc, fe_cnt, ov_cnt, pe_cnt);
    end
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (20) @(negedge clk_i);
    n_tests++;
    if (rxq.size() !== 1 || rxq[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL glitch_next got n=%0d d=%h want n=1 d=5a", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
    end
  endtask

  task automatic test_frame_err();
    clear_mon();
    ready_i = 1'b1;
    send_frame(8'h81, 1'b0, 1'b1);
    repeat (40) @(negedge clk_i);
    n_tests++;
    if (fe_cnt !== 1) begin
      n_fail++; $display("FAIL frame_err_pulse got %0d want 1", fe_cnt);
    end
    n_tests++;
    if (vcyc !== 0) begin
      n_fail++; $display("FAIL frame_err_valid got %0d want 0", vcyc);
    end
  endtask

  task automatic test_overrun();
    clear_mon();
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    repeat (20) @(negedge clk_i);
    n_tests++;
    if (valid_o !== 1'b1 || data_o !== 8'h11) begin
      n_fail++; $display("FAIL ovr_hold got v=%b d=%h want v=1 d=11", valid_o, data_o);
    end
    n_tests++;
    if (ov_cnt !== 1) begin
      n_fail++; $display("FAIL ovr_pulse got %0d want 1", ov_cnt);
    end
    ready_i = 1'b1;
    repeat (10) @(negedge clk_i);
    n_tests++;
    if (rxq.size() !== 1 || rxq[0] !== 8'h11) begin
      n_fail++;
      $display("FAIL ovr_drain got n=%0d d=%h want n=1 d=11", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
    end
    n_tests++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL ovr_valid_clear got %b want 0", valid_o);
    end
  endtask

  task automatic test_reset_mid_and_parity();
    logic [7:0] d;
    d = 8'h77;
    clear_mon();
    ready_i = 1'b1;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(d[i], CPB);
    drive_bit(d[3], CPB / 2);
    reset_i = 1'b1;
    rx_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_tests++;
    if ({data_o, valid_o, frame_err_o, overrun_o, parity_err_o} !== 12'h000) begin
      n_fail++;
      $display("FAIL midrst_outs got d=%h v=%b fe=%b ov=%b pe=%b want 0",
               data_o, valid_o, frame_err_o, overrun_o, parity_err_o);
    end
    reset_i = 1'b0;
    repeat (12 * CPB) @(negedge clk_i);
    n_tests++;
    if (vcyc + fe_cnt + ov_cnt + pe_cnt !== 0) begin
      n_fail++;
      $display("FAIL midrst_quiet got v=%0d fe=%0d ov=%0d pe=%0d want 0", vcyc, fe_cnt, ov_cnt, pe_cnt);
    end
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (20) @(negedge clk_i);
`ifdef UART_RX_PARITY_EN
    n_tests++;
    if (pe_cnt !== 1) begin
      n_fail++; $display("FAIL parity_pulse got %0d want 1", pe_cnt);
    end
    n_tests++;
    if (vcyc !== 0 || fe_cnt !== 0) begin
      n_fail++; $display("FAIL parity_discard got v=%0d fe=%0d want 0", vcyc, fe_cnt);
    end
`else
    n_tests++;
    if (pe_cnt !== 0) begin
      n_fail++; $display("FAIL parity_tied got %0d want 0", pe_cnt);
    end
    n_tests++;
    if (rxq.size() !== 1 || rxq[0] !== 8'h07) begin
      n_fail++;
      $display("FAIL after_rst_byte got n=%0d d=%h want n=1 d=07", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_and_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
